decode_stage: RTL and testbench

Registered RV32I decode stage for the pipelined core, sitting between fetch and execute. Accepts one instruction per cycle over a valid/ready handshake and emits fully decoded control fields with all five immediate formats sign-extended to XLEN. Adds load-use bubble insertion, flush and illegal-instruction flagging, none of which the current combinational decoder provides.

---
 rtl/decode_stage.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: registered bundle between fetch and execute with
// load-use bubble insertion, flush and illegal-instruction flagging.
//
// Handshake: a transfer happens on a cycle where valid && ready are both 1;
// valid never depends on ready, and a held bundle stays stable while
// out_valid && !out_ready.
module decode_stage #(
  parameter int XLEN      = 32,
  parameter bit SYSTEM_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic [3:0]      alu_op,
  output logic            alu_src_imm,
  output logic [XLEN-1:0] imm,
  output logic            writeback_en,
  output logic            use_rs1,
  output logic            use_rs2,
  output logic            is_load,
  output logic            is_store,
  output logic            is_branch,
  output logic            is_jal,
  output logic            is_jalr,
  output logic            is_lui,
  output logic            is_auipc,
  output logic            is_system,
  output logic            illegal,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_FULL   = 2'd1,
    S_BUBBLE = 2'd2
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  state_t state_q, state_d;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] d_rd, d_rs1, d_rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [3:0]      d_alu_op;
  logic            d_src_imm;
  logic [XLEN-1:0] d_imm;
  logic            d_wb, d_u1, d_u2;
  logic            d_load, d_store, d_branch, d_jal, d_jalr, d_lui, d_auipc, d_system;
  logic            d_bad;

  logic hazard;
  logic take;

  // Sign-extend a 32-bit immediate to the datapath width.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [XLEN-1:0] r;
    r = $signed(v);
    return r;
  endfunction

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign d_rd   = in_instr[11:7];
  assign d_rs1  = in_instr[19:15];
  assign d_rs2  = in_instr[24:20];

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  // Combinational decode of the incoming instruction.
  always_comb begin
    d_alu_op  = 4'b0000;
    d_src_imm = 1'b0;
    d_imm     = '0;
    d_wb      = 1'b0;
    d_u1      = 1'b0;
    d_u2      = 1'b0;
    d_load    = 1'b0;
    d_store   = 1'b0;
    d_branch  = 1'b0;
    d_jal     = 1'b0;
    d_jalr    = 1'b0;
    d_lui     = 1'b0;
    d_auipc   = 1'b0;
    d_system  = 1'b0;
    d_bad     = 1'b0;
    case (opcode)
      OPC_OP: begin
        d_wb     = 1'b1;
        d_u1     = 1'b1;
        d_u2     = 1'b1;
        d_alu_op = {f7[5], f3};
        if (f7 != 7'b0000000 && f7 != 7'b0100000) d_bad = 1'b1;
        if (f7 == 7'b0100000 && f3 != 3'b000 && f3 != 3'b101) d_bad = 1'b1;
      end
      OPC_OPIMM: begin
        d_wb      = 1'b1;
        d_u1      = 1'b1;
        d_src_imm = 1'b1;
        d_imm     = sext32(imm_i);
        d_alu_op  = {(f3 == 3'b101) ? f7[5] : 1'b0, f3};
        if (f3 == 3'b001 && f7 != 7'b0000000) d_bad = 1'b1;
        if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) d_bad = 1'b1;
      end
      OPC_LOAD: begin
        d_wb      = 1'b1;
        d_u1      = 1'b1;
        d_src_imm = 1'b1;
        d_load    = 1'b1;
        d_imm     = sext32(imm_i);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) d_bad = 1'b1;
      end
      OPC_STORE: begin
        d_u1      = 1'b1;
        d_u2      = 1'b1;
        d_src_imm = 1'b1;
        d_store   = 1'b1;
        d_imm     = sext32(imm_s);
        if (f3 >= 3'b011) d_bad = 1'b1;
      end
      OPC_BRANCH: begin
        d_u1     = 1'b1;
        d_u2     = 1'b1;
        d_branch = 1'b1;
        d_imm    = sext32(imm_b);
        d_alu_op = {1'b0, f3};
        if (f3 == 3'b010 || f3 == 3'b011) d_bad = 1'b1;
      end
      OPC_JAL: begin
        d_wb  = 1'b1;
        d_jal = 1'b1;
        d_imm = sext32(imm_j);
      end
      OPC_JALR: begin
        d_wb      = 1'b1;
        d_u1      = 1'b1;
        d_src_imm = 1'b1;
        d_jalr    = 1'b1;
        d_imm     = sext32(imm_i);
        if (f3 != 3'b000) d_bad = 1'b1;
      end
      OPC_LUI: begin
        d_wb      = 1'b1;
        d_src_imm = 1'b1;
        d_lui     = 1'b1;
        d_imm     = sext32(imm_u);
      end
      OPC_AUIPC: begin
        d_wb      = 1'b1;
        d_src_imm = 1'b1;
        d_auipc   = 1'b1;
        d_imm     = sext32(imm_u);
      end
      OPC_SYSTEM: begin
        if (SYSTEM_EN) d_system = 1'b1;
        else           d_bad    = 1'b1;
      end
      default: d_bad = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) d_bad = 1'b1;
    // x0 is never written and never a real dependency.
    if (d_rd  == 5'd0) d_wb = 1'b0;
    if (d_rs1 == 5'd0) d_u1 = 1'b0;
    if (d_rs2 == 5'd0) d_u2 = 1'b0;
    // Illegal instructions travel downstream as inert bundles that only trap.
    if (d_bad) begin
      d_wb     = 1'b0;
      d_u1     = 1'b0;
      d_u2     = 1'b0;
      d_load   = 1'b0;
      d_store  = 1'b0;
      d_branch = 1'b0;
      d_jal    = 1'b0;
      d_jalr   = 1'b0;
      d_lui    = 1'b0;
      d_auipc  = 1'b0;
      d_system = 1'b0;
    end
  end

  // Load-use check: the held load is leaving this cycle and the incoming
  // instruction needs its result, which execute cannot forward in time.
  always_comb begin
    hazard = out_valid && is_load && (rd_addr != 5'd0) && out_ready &&
             ((d_u1 && d_rs1 == rd_addr) || (d_u2 && d_rs2 == rd_addr));
  end

  assign out_valid = (state_q == S_FULL);
  assign dbg_state = state_q;
  assign in_ready  = !rst && !flush && (state_q != S_BUBBLE) &&
                     (!out_valid || out_ready) && !hazard;
  assign take      = in_valid && in_ready;

  // Next-state logic; flush wins over transfer and hazard.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY:  if (take) state_d = S_FULL;
      S_FULL: begin
        if (take)                    state_d = S_FULL;
        else if (in_valid && hazard) state_d = S_BUBBLE;
        else if (out_ready)          state_d = S_EMPTY;
      end
      S_BUBBLE: state_d = S_EMPTY;
      default:  state_d = S_EMPTY;
    endcase
    if (flush) state_d = S_EMPTY;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  // Bundle register, loaded only on an accepted transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_pc       <= '0;
      rs1_addr     <= '0;
      rs2_addr     <= '0;
      rd_addr      <= '0;
      alu_op       <= '0;
      alu_src_imm  <= 1'b0;
      imm          <= '0;
      writeback_en <= 1'b0;
      use_rs1      <= 1'b0;
      use_rs2      <= 1'b0;
      is_load      <= 1'b0;
      is_store     <= 1'b0;
      is_branch    <= 1'b0;
      is_jal       <= 1'b0;
      is_jalr      <= 1'b0;
      is_lui       <= 1'b0;
      is_auipc     <= 1'b0;
      is_system    <= 1'b0;
      illegal      <= 1'b0;
    end else if (take) begin
      out_pc       <= in_pc;
      rs1_addr     <= d_rs1;
      rs2_addr     <= d_rs2;
      rd_addr      <= d_rd;
      alu_op       <= d_alu_op;
      alu_src_imm  <= d_src_imm;
      imm          <= d_imm;
      writeback_en <= d_wb;
      use_rs1      <= d_u1;
      use_rs2      <= d_u2;
      is_load      <= d_load;
      is_store     <= d_store;
      is_branch    <= d_branch;
      is_jal       <= d_jal;
      is_jalr      <= d_jalr;
      is_lui       <= d_lui;
      is_auipc     <= d_auipc;
      is_system    <= d_system;
      illegal      <= d_bad;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed handshake/hazard/flush scenarios plus a
// random stream, with a scoreboard of hand-encoded expected bundles.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready, out_valid;
  logic [31:0] out_pc, imm;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [3:0]  alu_op;
  logic        alu_src_imm, writeback_en, use_rs1, use_rs2;
  logic        is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc, is_system, illegal;
  logic [1:0]  dbg_state;

  logic        n_in_ready, n_out_valid;
  logic [31:0] n_out_pc, n_imm;
  logic [4:0]  n_rs1, n_rs2, n_rd;
  logic [3:0]  n_alu_op;
  logic        n_src, n_wb, n_u1, n_u2;
  logic        n_ld, n_st, n_br, n_jal, n_jalr, n_lui, n_auipc, n_sys, n_ill;
  logic [1:0]  n_dbg;

  decode_stage #(.XLEN(32), .SYSTEM_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .imm(imm), .writeback_en(writeback_en),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .is_load(is_load), .is_store(is_store),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .is_lui(is_lui),
    .is_auipc(is_auipc), .is_system(is_system), .illegal(illegal), .dbg_state(dbg_state)
  );

  decode_stage #(.XLEN(32), .SYSTEM_EN(1'b0)) u_dut_nosys (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(n_out_valid), .out_ready(out_ready),
    .out_pc(n_out_pc), .rs1_addr(n_rs1), .rs2_addr(n_rs2), .rd_addr(n_rd),
    .alu_op(n_alu_op), .alu_src_imm(n_src), .imm(n_imm), .writeback_en(n_wb),
    .use_rs1(n_u1), .use_rs2(n_u2), .is_load(n_ld), .is_store(n_st),
    .is_branch(n_br), .is_jal(n_jal), .is_jalr(n_jalr), .is_lui(n_lui),
    .is_auipc(n_auipc), .is_system(n_sys), .illegal(n_ill), .dbg_state(n_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Stimulus table: instruction with hand-computed imm, alu_op, alu_src_imm and
  // flags {wb,use_rs1,use_rs2,load,store,branch,jal,jalr,lui,auipc,system,illegal}.
  localparam int NV = 20;
  logic [31:0] t_instr [NV];
  logic [31:0] t_imm   [NV];
  logic [3:0]  t_aop   [NV];
  logic        t_src   [NV];
  logic [11:0] t_fl    [NV];

  task automatic set_vec(input int i, input logic [31:0] ins, input logic [31:0] im,
                         input logic [3:0] aop, input logic src, input logic [11:0] fl);
    t_instr[i] = ins; t_imm[i] = im; t_aop[i] = aop; t_src[i] = src; t_fl[i] = fl;
  endtask

  initial begin
    set_vec( 0, 32'hFFB00093, 32'hFFFFFFFB, 4'b0000, 1'b1, 12'b1000_0000_0000); // addi x1,x0,-5
    set_vec( 1, 32'h00012283, 32'h00000000, 4'b0000, 1'b1, 12'b1101_0000_0000); // lw x5,0(x2)
    set_vec( 2, 32'h00728333, 32'h00000000, 4'b0000, 1'b0, 12'b1110_0000_0000); // add x6,x5,x7
    set_vec( 3, 32'h00700333, 32'h00000000, 4'b0000, 1'b0, 12'b1010_0000_0000); // add x6,x0,x7
    set_vec( 4, 32'hFE208EE3, 32'hFFFFFFFC, 4'b0000, 1'b0, 12'b0110_0100_0000); // beq x1,x2,-4
    set_vec( 5, 32'h001000EF, 32'h00000800, 4'b0000, 1'b0, 12'b1000_0010_0000); // jal x1,+2048
    set_vec( 6, 32'hFE322FA3, 32'hFFFFFFFF, 4'b0000, 1'b1, 12'b0110_1000_0000); // sw x3,-1(x4)
    set_vec( 7, 32'h00000000, 32'h00000000, 4'b0000, 1'b0, 12'b0000_0000_0001); // all zero
    set_vec( 8, 32'h40001033, 32'h00000000, 4'b1001, 1'b0, 12'b0000_0000_0001); // sub f3=001
    set_vec( 9, 32'h00000013, 32'h00000000, 4'b0000, 1'b1, 12'b0000_0000_0000); // addi x0,x0,0
    set_vec(10, 32'h00000073, 32'h00000000, 4'b0000, 1'b0, 12'b0000_0000_0010); // ecall
    set_vec(11, 32'h12345537, 32'h12345000, 4'b0000, 1'b1, 12'b1000_0000_1000); // lui x10
    set_vec(12, 32'hFFFFF597, 32'hFFFFF000, 4'b0000, 1'b1, 12'b1000_0000_0100); // auipc x11
    set_vec(13, 32'h4036D613, 32'h00000403, 4'b1101, 1'b1, 12'b1100_0000_0000); // srai x12,x13,3
    set_vec(14, 32'h008280E7, 32'h00000008, 4'b0000, 1'b1, 12'b1100_0001_0000); // jalr x1,8(x5)
    set_vec(15, 32'h40109093, 32'h00000401, 4'b0001, 1'b1, 12'b0000_0000_0001); // slli bad f7
    set_vec(16, 32'h00013283, 32'h00000000, 4'b0000, 1'b1, 12'b0000_0000_0001); // load f3=011
    set_vec(17, 32'hFE20AEE3, 32'hFFFFFFFC, 4'b0010, 1'b0, 12'b0000_0000_0001); // branch f3=010
    set_vec(18, 32'h40838333, 32'h00000000, 4'b1000, 1'b0, 12'b1110_0000_0000); // sub x6,x7,x8
    set_vec(19, 32'h008290E7, 32'h00000008, 4'b0000, 1'b1, 12'b0000_0000_0001); // jalr f3=001
  end

  // Scoreboard
  logic [95:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cur_idx;
  logic [31:0] pc_ctr = 32'h0000_1000;
  logic [95:0] obs_pack;

  function automatic logic [95:0] pack(input logic [4:0] rd, input logic [4:0] r1,
                                       input logic [4:0] r2, input logic [3:0] aop,
                                       input logic src, input logic [31:0] im,
                                       input logic [11:0] fl, input logic [31:0] pc);
    return {rd, r1, r2, aop, src, im, fl, pc};
  endfunction

  assign obs_pack = pack(rd_addr, rs1_addr, rs2_addr, alu_op, alu_src_imm, imm,
                         {writeback_en, use_rs1, use_rs2, is_load, is_store, is_branch,
                          is_jal, is_jalr, is_lui, is_auipc, is_system, illegal}, out_pc);

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_cur();
    logic [31:0] ins;
    ins = t_instr[cur_idx];
    exp_q.push_back(pack(ins[11:7], ins[19:15], ins[24:20], t_aop[cur_idx], t_src[cur_idx],
                         t_imm[cur_idx], t_fl[cur_idx], in_pc));
  endtask

  // Output monitor: every bundle handed downstream must match the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      chk("q_nonempty", (exp_q.size() != 0), 1'b1);
      if (exp_q.size() != 0) chk("bundle", obs_pack, exp_q.pop_front());
    end
  end

  // Driver tasks; all return on the posedge+1 phase.
  task automatic offer(input int idx);
    cur_idx  = idx;
    pc_ctr   = pc_ctr + 32'd4;
    in_pc    = pc_ctr;
    in_instr = t_instr[idx];
    in_valid = 1'b1;
  endtask

  task automatic send(input int idx);
    bit acc;
    acc = 1'b0;
    offer(idx);
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (in_ready) begin
        push_cur();
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk("send_acc", acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic step(input string tag, input logic er, input logic ev, input logic [1:0] es);
    @(negedge clk);
    chk({tag, "_rdy"}, in_ready, er);
    chk({tag, "_vld"}, out_valid, ev);
    chk({tag, "_st"}, dbg_state, es);
    if (in_valid && in_ready) push_cur();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] pc_a;
  bit          rand_done;

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'hFFB00093; in_pc = 32'h0;

    // Reset: nothing accepted, bundle cleared
    @(negedge clk);
    chk("rst_rdy", in_ready, 1'b0);
    chk("rst_vld", out_valid, 1'b0);
    chk("rst_st", dbg_state, 2'd0);
    chk("rst_bundle", obs_pack, 96'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0;

    // First instruction, one-cycle latency
    send(0);
    @(negedge clk);
    chk("lat_vld", out_valid, 1'b1);
    @(posedge clk); #1;
    drain();

    // Backpressure: held bundle stable, next one accepted on release
    out_ready = 1'b0;
    send(0);
    pc_a = pc_ctr;
    offer(5);
    for (int k = 0; k < 3; k++) begin
      step("bp_hold", 1'b0, 1'b1, 2'd1);
      chk("bp_pc", out_pc, pc_a);
    end
    out_ready = 1'b1;
    step("bp_release", 1'b1, 1'b1, 2'd1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_vld", out_valid, 1'b1);
    chk("bp_next_pc", out_pc, pc_ctr);
    @(posedge clk); #1;
    drain();

    // Load-use: one bubble, then the dependent add
    send(1);
    offer(2);
    step("lu_stall", 1'b0, 1'b1, 2'd1);
    step("lu_bubble", 1'b0, 1'b0, 2'd2);
    step("lu_accept", 1'b1, 1'b0, 2'd0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lu_out_vld", out_valid, 1'b1);
    @(posedge clk); #1;
    drain();

    // No hazard when the consumer reads x0 and x7
    send(1);
    offer(3);
    step("nolu", 1'b1, 1'b1, 2'd1);
    in_valid = 1'b0;
    drain();

    // Immediates, illegal encodings, x0 destination, system
    for (int i = 4; i < NV; i++) begin
      send(i);
      if (i == 10) begin
        @(negedge clk);
        chk("nosys_vld", n_out_valid, 1'b1);
        chk("nosys_ill", n_ill, 1'b1);
        chk("nosys_sys", n_sys, 1'b0);
        @(posedge clk); #1;
      end
    end
    drain();

    // Flush while FULL: held bundle killed, nothing accepted that cycle
    out_ready = 1'b0;
    send(0);
    offer(5);
    flush = 1'b1;
    step("fl_full", 1'b0, 1'b1, 2'd1);
    flush = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    step("fl_after", 1'b1, 1'b0, 2'd0);
    in_valid = 1'b0;
    drain();

    // Flush during a bubble
    send(1);
    offer(2);
    step("fb_stall", 1'b0, 1'b1, 2'd1);
    flush = 1'b1;
    step("fb_flush", 1'b0, 1'b0, 2'd2);
    flush = 1'b0;
    step("fb_after", 1'b1, 1'b0, 2'd0);
    in_valid = 1'b0;
    drain();

    // Random stream with random downstream backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 60; n++) send($urandom_range(0, NV - 1));
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    chk("drain_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
